seg_display_capture: RTL and testbench
======================================

Name: seg_display_capture

Overview:
Receive-side monitor for the multiplexed 7-segment display bus that the digital tube driver produces (segments plus digit select). It samples the segment/select lines, waits for each scanned digit to be stable, and decodes the segment pattern back to a hex nibble per digit position. Used on the debug path to expose the currently displayed values as binary, and as the checker end of the display interface in self-test builds.

Parameters:
NUM_DIGITS, 2, number of scanned digit positions (width of i_sel); legal range 1..8
STABLE_CYCLES, 16, consecutive identical samples required before a digit is committed; minimum 2
SEG_ACTIVE_LOW, 0, 1 = segment and select inputs are active-low; both are inverted at the sampler

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous reset, active-high
i_digitalTube  input  7  segment lines, bit0=a .. bit6=g
i_sel  input  NUM_DIGITS  digit select; exactly one bit active = a valid scan slot
o_digits  output  4*NUM_DIGITS  decoded nibbles; digit n occupies [4n+3:4n]
o_digit_valid  output  NUM_DIGITS  digit n currently shows a decodable glyph
o_update  output  1  one-cycle pulse when a committed digit changes value or validity
o_update_idx  output  3  index of the digit that changed; meaningful only while o_update=1
o_err  output  1  one-cycle pulse when a committed pattern is not in the glyph table
o_err_cnt  output  8  saturating error count (see Optional Feature)

Behaviour:
- Reset (synchronous, i_rst=1 at a rising edge): o_digits=0, o_digit_valid=0, o_update=0, o_update_idx=0, o_err=0, o_err_cnt=0, FSM=S_TRACK, counter=0, sync registers=0.
- Sampler: {i_sel, i_digitalTube} passes through a 2-flop synchronizer. Polarity inversion is applied before the first flop when SEG_ACTIVE_LOW=1. All further logic uses only the second-stage value (s2).
- Stability counter: compare s2 with the previous s2. If they differ, counter=1 and FSM=S_TRACK. If they are equal, counter increments and saturates at STABLE_CYCLES.
- FSM S_TRACK: when the counter reaches STABLE_CYCLES and the select field is exactly one-hot, perform a commit on the next edge and go to S_DONE. A zero or multi-hot select never commits and stays in S_TRACK.
- FSM S_DONE: no further commits. Any change in s2 returns the FSM to S_TRACK with counter=1.
- Commit to digit n = index of the set select bit:
  - Valid glyph: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Write the nibble and set valid[n]. Pulse o_update with o_update_idx=n only if the nibble or valid[n] changed.
  - Blank (00): clear valid[n] and leave the nibble unchanged. Pulse o_update only if valid[n] was 1.
  - Any other pattern: digit unchanged; pulse o_err.
- Latency: o_update/o_err rises exactly STABLE_CYCLES+2 edges after the input pair is first presented stable. All outputs are registered.
- o_update and o_err are never asserted in the same cycle. At most one commit occurs per stable window.
- Reset mid-count: the pending commit is discarded and there is no pulse after reset is released.
- Continuous scanning (select rotating): each slot is committed independently, provided each slot dwells for at least STABLE_CYCLES+1 cycles.

Optional Feature:
SEG_CAPTURE_ERRCNT_EN
- Defined: o_err_cnt increments on each o_err pulse, saturates at 255, and is cleared only by reset.
- Undefined: the counter logic is omitted and o_err_cnt is tied to 0. The port list is identical in both builds.

Test Plan:
- Reset, then sel=01, seg=5B held for 10 cycles, STABLE_CYCLES=4 -> o_update pulses once at edge 6 with idx=0; o_digits[3:0]=2; o_digit_valid=01.
- Same slot: seg toggles 5B/4F every 3 cycles, STABLE_CYCLES=4 -> no o_update, digits unchanged; then seg=4F held -> one pulse, nibble=3.
- Scan sel 01 (seg 06) and 10 (seg 71), 8 cycles each, repeated 4 times -> exactly two o_update pulses (idx 0, then 1); o_digits=8'hF1; later scans produce no further pulses.
- sel=01, seg=7F held -> nibble 8; then seg=00 held -> o_update with valid[0]=0; then seg=00 again after a glitch -> no pulse.
- sel=01, seg=49 held -> single o_err pulse, o_digits unchanged; with SEG_CAPTURE_ERRCNT_EN, o_err_cnt=1; 300 such events -> 255; without the macro, o_err_cnt stays 0.
- sel=11 or 00 with seg=3F held for 50 cycles -> no o_update and no o_err; assert i_rst on the cycle before an expected commit -> no pulse, all outputs 0.

Source files
------------

// File: rtl/seg_display_capture.sv
// seg_display_capture: receive-side monitor for a multiplexed 7-segment bus.
// Synchronises {select, segments}, waits for each scanned slot to be stable,
// then decodes the glyph back to a hex nibble for that digit position.
// Optional build macro: SEG_CAPTURE_ERRCNT_EN (saturating count of o_err pulses;
// when undefined, o_err_cnt is tied to zero).
module seg_display_capture #(
    parameter int unsigned NUM_DIGITS     = 2,
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [6:0]              i_digitalTube,
    input  logic [NUM_DIGITS-1:0]   i_sel,
    output logic [4*NUM_DIGITS-1:0] o_digits,
    output logic [NUM_DIGITS-1:0]   o_digit_valid,
    output logic                    o_update,
    output logic [2:0]              o_update_idx,
    output logic                    o_err,
    output logic [7:0]              o_err_cnt
);

    localparam int unsigned SW = NUM_DIGITS + 7;
    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    localparam logic [0:0] S_TRACK = 1'b0;
    localparam logic [0:0] S_DONE  = 1'b1;

    // Glyph table lookup: returns {hit, nibble}.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = 5'b0;
        endcase
        return r;
    endfunction

    logic [SW-1:0]           raw;
    logic [SW-1:0]           s1_q, s1_d;
    logic [SW-1:0]           s2_q, s2_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [0:0]              state_q, state_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    update_q, update_d;
    logic [2:0]              idx_q, idx_d;
    logic                    err_q, err_d;

    logic [NUM_DIGITS-1:0]   cur_sel;
    logic [6:0]              cur_seg;
    logic [4:0]              glyph;
    logic                    changed;
    logic                    commit;

    // Polarity normalisation ahead of the first synchroniser stage.
    assign raw = {i_sel, i_digitalTube} ^ {SW{SEG_ACTIVE_LOW}};

    // Stability tracking, commit decision and digit update.
    always_comb begin
        s1_d     = raw;
        s2_d     = s1_q;
        cur_sel  = s2_q[SW-1:7];
        cur_seg  = s2_q[6:0];
        glyph    = decode_glyph(cur_seg);
        // s1 is the next s2, so this compares the incoming s2 with the current one
        changed  = (s1_q != s2_q);
        commit   = (state_q == S_TRACK) && (cnt_q == CNT_MAX) && $onehot(cur_sel);

        if (changed) begin
            cnt_d = CW'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (changed) begin
            state_d = S_TRACK;
        end else if (commit) begin
            state_d = S_DONE;
        end else begin
            state_d = state_q;
        end

        digits_d = digits_q;
        valid_d  = valid_q;
        update_d = 1'b0;
        idx_d    = idx_q;
        err_d    = 1'b0;

        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (commit && cur_sel[i]) begin
                if (cur_seg == 7'h00) begin
                    if (valid_q[i]) begin
                        valid_d[i] = 1'b0;
                        update_d   = 1'b1;
                        idx_d      = 3'(i);
                    end
                end else if (glyph[4]) begin
                    if (!valid_q[i] || (digits_q[4*i +: 4] != glyph[3:0])) begin
                        update_d = 1'b1;
                        idx_d    = 3'(i);
                    end
                    digits_d[4*i +: 4] = glyph[3:0];
                    valid_d[i]         = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            cnt_q    <= '0;
            state_q  <= S_TRACK;
            digits_q <= '0;
            valid_q  <= '0;
            update_q <= 1'b0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            update_q <= update_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

`ifdef SEG_CAPTURE_ERRCNT_EN
    logic [7:0] errcnt_q, errcnt_d;

    // Saturating error count, stepped in the same edge that raises o_err.
    always_comb begin
        errcnt_d = errcnt_q;
        if (err_d && (errcnt_q != 8'hFF)) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    // Error counter register, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            errcnt_q <= '0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign o_err_cnt = errcnt_q;
`else
    assign o_err_cnt = '0;
`endif

    assign o_digits      = digits_q;
    assign o_digit_valid = valid_q;
    assign o_update      = update_q;
    assign o_update_idx  = idx_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_seg_display_capture.sv
// Directed, table-driven bench for seg_display_capture (NUM_DIGITS=2, STABLE_CYCLES=4).
module tb_seg_display_capture;

`ifdef SEG_CAPTURE_ERRCNT_EN
    localparam bit ERRCNT_ON = 1'b1;
`else
    localparam bit ERRCNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg;
    logic [1:0] sel;
    logic [7:0] digits;
    logic [1:0] dvalid;
    logic       upd;
    logic [2:0] upd_idx;
    logic       err;
    logic [7:0] err_cnt;

    seg_display_capture #(
        .NUM_DIGITS     (2),
        .STABLE_CYCLES  (4),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_digitalTube (seg),
        .i_sel         (sel),
        .o_digits      (digits),
        .o_digit_valid (dvalid),
        .o_update      (upd),
        .o_update_idx  (upd_idx),
        .o_err         (err),
        .o_err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // pulse monitor, sampled on the falling edge
    int         upd_seen  = 0;
    int         err_seen  = 0;
    int         both_seen = 0;
    logic [2:0] last_idx  = '0;

    always @(negedge clk) begin
        if (upd) begin
            upd_seen = upd_seen + 1;
            last_idx = upd_idx;
        end
        if (err) err_seen = err_seen + 1;
        if (upd && err) both_seen = both_seen + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        upd_seen = 0;
        err_seen = 0;
    endtask

    typedef struct {
        logic [1:0] sel;
        logic [6:0] seg;
        int         hold;
        int         upd;
        int         err;
        logic [2:0] idx;
        logic [7:0] digits;
        logic [1:0] valid;
        logic [7:0] ec;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    initial begin
        // toggling faster than the stability window, then a long hold
        vecs[0]  = '{2'b01, 7'h4F,  3, 0, 0, 3'd0, 8'h02, 2'b01, 8'd0};
        vecs[1]  = '{2'b01, 7'h5B,  3, 0, 0, 3'd0, 8'h02, 2'b01, 8'd0};
        vecs[2]  = '{2'b01, 7'h4F,  3, 0, 0, 3'd0, 8'h02, 2'b01, 8'd0};
        vecs[3]  = '{2'b01, 7'h5B,  3, 0, 0, 3'd0, 8'h02, 2'b01, 8'd0};
        vecs[4]  = '{2'b01, 7'h4F, 10, 1, 0, 3'd0, 8'h03, 2'b01, 8'd0};
        // scanning two slots, four rounds
        vecs[5]  = '{2'b01, 7'h06,  8, 1, 0, 3'd0, 8'h01, 2'b01, 8'd0};
        vecs[6]  = '{2'b10, 7'h71,  8, 1, 0, 3'd1, 8'hF1, 2'b11, 8'd0};
        vecs[7]  = '{2'b01, 7'h06,  8, 0, 0, 3'd0, 8'hF1, 2'b11, 8'd0};
        vecs[8]  = '{2'b10, 7'h71,  8, 0, 0, 3'd0, 8'hF1, 2'b11, 8'd0};
        vecs[9]  = '{2'b01, 7'h06,  8, 0, 0, 3'd0, 8'hF1, 2'b11, 8'd0};
        vecs[10] = '{2'b10, 7'h71,  8, 0, 0, 3'd0, 8'hF1, 2'b11, 8'd0};
        vecs[11] = '{2'b01, 7'h06,  8, 0, 0, 3'd0, 8'hF1, 2'b11, 8'd0};
        vecs[12] = '{2'b10, 7'h71,  8, 0, 0, 3'd0, 8'hF1, 2'b11, 8'd0};
        // blanking, and re-blanking after a short glitch
        vecs[13] = '{2'b01, 7'h7F, 10, 1, 0, 3'd0, 8'hF8, 2'b11, 8'd0};
        vecs[14] = '{2'b01, 7'h00, 10, 1, 0, 3'd0, 8'hF8, 2'b10, 8'd0};
        vecs[15] = '{2'b01, 7'h06,  2, 0, 0, 3'd0, 8'hF8, 2'b10, 8'd0};
        vecs[16] = '{2'b01, 7'h00, 10, 0, 0, 3'd0, 8'hF8, 2'b10, 8'd0};
        // undecodable pattern
        vecs[17] = '{2'b01, 7'h49, 10, 0, 1, 3'd0, 8'hF8, 2'b10, 8'd1};
        // invalid select fields never commit
        vecs[18] = '{2'b11, 7'h3F, 50, 0, 0, 3'd0, 8'hF8, 2'b10, 8'd1};
        vecs[19] = '{2'b00, 7'h3F, 50, 0, 0, 3'd0, 8'hF8, 2'b10, 8'd1};
        vecs[20] = '{2'b10, 7'h3F, 10, 1, 0, 3'd1, 8'h08, 2'b10, 8'd1};
        vecs[21] = '{2'b01, 7'h7C, 10, 1, 0, 3'd0, 8'h0B, 2'b11, 8'd1};

        rst = 1'b1;
        sel = '0;
        seg = '0;
        tick();
        tick();
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_valid", 32'(dvalid), 32'h0);
        check("reset_update", 32'(upd), 32'h0);
        check("reset_idx", 32'(upd_idx), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_errcnt", 32'(err_cnt), 32'h0);

        // latency: pulse exactly at edge STABLE_CYCLES+2 = 6
        rst = 1'b0;
        sel = 2'b01;
        seg = 7'h5B;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("latency_update_edge%0d", k), 32'(upd), (k == 6) ? 32'd1 : 32'd0);
            if (k == 6) check("latency_idx", 32'(upd_idx), 32'd0);
        end
        check("latency_digits", 32'(digits), 32'h02);
        check("latency_valid", 32'(dvalid), 32'h1);

        for (int v = 0; v < NV; v++) begin
            clear_mon();
            sel = vecs[v].sel;
            seg = vecs[v].seg;
            for (int c = 0; c < vecs[v].hold; c++) tick();
            check($sformatf("vec%0d_updates", v), 32'(upd_seen), 32'(vecs[v].upd));
            check($sformatf("vec%0d_errs", v), 32'(err_seen), 32'(vecs[v].err));
            if (vecs[v].upd > 0)
                check($sformatf("vec%0d_idx", v), 32'(last_idx), 32'(vecs[v].idx));
            check($sformatf("vec%0d_digits", v), 32'(digits), 32'(vecs[v].digits));
            check($sformatf("vec%0d_valid", v), 32'(dvalid), 32'(vecs[v].valid));
            check($sformatf("vec%0d_errcnt", v), 32'(err_cnt),
                  ERRCNT_ON ? 32'(vecs[v].ec) : 32'd0);
        end

        // 300 further error events: counter saturates at 255
        clear_mon();
        sel = 2'b01;
        for (int e = 0; e < 300; e++) begin
            seg = (e % 2 == 0) ? 7'h49 : 7'h4A;
            for (int c = 0; c < 8; c++) tick();
        end
        check("storm_err_pulses", 32'(err_seen), 32'd300);
        check("storm_updates", 32'(upd_seen), 32'd0);
        check("storm_errcnt", 32'(err_cnt), ERRCNT_ON ? 32'd255 : 32'd0);
        check("storm_digits", 32'(digits), 32'h0B);
        check("update_err_exclusive", 32'(both_seen), 32'd0);

        // reset one edge before a commit would occur
        sel = 2'b01;
        seg = 7'h06;
        for (int c = 0; c < 5; c++) tick();
        clear_mon();
        rst = 1'b1;
        sel = '0;
        seg = '0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        check("rstmid_updates", 32'(upd_seen), 32'd0);
        check("rstmid_errs", 32'(err_seen), 32'd0);
        check("rstmid_digits", 32'(digits), 32'h0);
        check("rstmid_valid", 32'(dvalid), 32'h0);
        check("rstmid_idx", 32'(upd_idx), 32'h0);
        check("rstmid_errcnt", 32'(err_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
